// File: rtl/aes_round_seq.sv
// AES round sequencer: steps the round count, registers the selector's four
// state words once per round, and hands the ciphertext out over valid/ready.
module aes_round_seq #(
  parameter int NR = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        key_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic [31:0] w,
  output logic [3:0]  count,
  output logic        key_flag,
  output logic        last_round,
  output logic [31:0] s0,
  output logic [31:0] s1,
  output logic [31:0] s2,
  output logic [31:0] s3,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam logic [3:0] LAST = 4'(NR + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        count_nxt;
  logic              kf_nxt, ov_nxt, cap;
  logic [3:0][31:0]  st, din;

  assign din = {w, z, y, x};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    kf_nxt    = key_flag;
    ov_nxt    = out_valid;
    cap       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        count_nxt = 4'd1;
        kf_nxt    = 1'b1;
      end
      RUN: if (key_valid) begin
        cap = 1'b1;
        if (count == LAST) begin
          state_nxt = DONE;
          count_nxt = 4'd0;
          kf_nxt    = 1'b0;
          ov_nxt    = 1'b1;
        end else begin
          count_nxt = count + 4'd1;
        end
      end
      // start is deliberately ignored on the accept edge
      DONE: if (out_ready) begin
        state_nxt = IDLE;
        ov_nxt    = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 4'd0;
      key_flag  <= 1'b0;
      out_valid <= 1'b0;
      st        <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      key_flag  <= kf_nxt;
      out_valid <= ov_nxt;
      if (cap) st <= din;
    end
  end

  assign last_round = (count == LAST);
  assign busy       = (state != IDLE);
  assign s0 = st[0];
  assign s1 = st[1];
  assign s2 = st[2];
  assign s3 = st[3];
endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: two instances (NR=10, NR=14) driven by a selector
// model (initial words at count 1, previous state + 1 otherwise).
module tb_aes_round_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start [2];
  logic        key_valid [2];
  logic        out_ready [2];
  logic [31:0] sel [2][4];
  logic [31:0] init [2][4];
  logic [3:0]  count [2];
  logic        key_flag [2], last_round [2], busy [2], out_valid [2];
  logic [31:0] s [2][4];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    for (genvar i = 0; i < 4; i++) begin : g_sel
      assign sel[g][i] = (count[g] == 4'd1) ? init[g][i] : s[g][i] + 32'd1;
    end
    aes_round_seq #(.NR(g == 0 ? 10 : 14)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .key_valid(key_valid[g]),
      .x(sel[g][0]), .y(sel[g][1]), .z(sel[g][2]), .w(sel[g][3]),
      .count(count[g]), .key_flag(key_flag[g]), .last_round(last_round[g]),
      .s0(s[g][0]), .s1(s[g][1]), .s2(s[g][2]), .s3(s[g][3]),
      .busy(busy[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, " count"}, 32'(count[d]), 32'd0);
    chk({tag, " busy"}, 32'(busy[d]), 32'd0);
    chk({tag, " key_flag"}, 32'(key_flag[d]), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid[d]), 32'd0);
    for (int i = 0; i < 4; i++) chk({tag, " s"}, s[d][i], 32'd0);
  endtask

  task automatic set_init(input int d, input bit rnd);
    logic [31:0] fixed [4];
    fixed = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    for (int i = 0; i < 4; i++) init[d][i] = rnd ? $urandom : fixed[i];
  endtask

  // One block: expected count advances on every key_valid edge, latency is
  // NR+1 plus stall cycles, ciphertext is the initial words plus NR.
  task automatic run_block(input int d, input int nr, input bit rnd_init,
                           input int stall_at, input int stall_len, input bit rnd_stall,
                           input int bp_cycles, input bit start_in_done);
    int exp_cnt, cyc, nstall, stalled;
    bit kv, fin;
    logic [31:0] exp_ct [4];
    set_init(d, rnd_init);
    for (int i = 0; i < 4; i++) exp_ct[i] = init[d][i] + 32'(nr);
    start[d] = 1'b1; key_valid[d] = 1'b0; out_ready[d] = 1'b0;
    step();
    start[d] = 1'b0;
    chk("start count", 32'(count[d]), 32'd1);
    chk("start busy", 32'(busy[d]), 32'd1);
    chk("start key_flag", 32'(key_flag[d]), 32'd1);
    exp_cnt = 1; cyc = 0; nstall = 0; stalled = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      if (rnd_stall) kv = ($urandom_range(0, 3) != 0);
      else kv = !(exp_cnt == stall_at && stalled < stall_len);
      key_valid[d] = kv;
      start[d] = $urandom_range(0, 1) == 1;
      chk("run count", 32'(count[d]), 32'(exp_cnt));
      chk("run last_round", 32'(last_round[d]), 32'(exp_cnt == nr + 1));
      chk("run out_valid", 32'(out_valid[d]), 32'd0);
      step();
      cyc++;
      if (!kv) begin nstall++; if (exp_cnt == stall_at) stalled++; end
      else if (exp_cnt == nr + 1) fin = 1'b1;
      else exp_cnt++;
    end
    start[d] = 1'b0; key_valid[d] = 1'b0;
    chk("run finished", 32'(fin), 32'd1);
    chk("latency", 32'(cyc), 32'(nr + 1 + nstall));
    chk("done out_valid", 32'(out_valid[d]), 32'd1);
    chk("done count", 32'(count[d]), 32'd0);
    chk("done key_flag", 32'(key_flag[d]), 32'd0);
    chk("done last_round", 32'(last_round[d]), 32'd0);
    for (int i = 0; i < 4; i++) chk("cipher", s[d][i], exp_ct[i]);
    for (int c = 0; c < bp_cycles; c++) begin
      start[d] = start_in_done;
      key_valid[d] = $urandom_range(0, 1) == 1;
      step();
      chk("bp out_valid", 32'(out_valid[d]), 32'd1);
      chk("bp busy", 32'(busy[d]), 32'd1);
      chk("bp count", 32'(count[d]), 32'd0);
      for (int i = 0; i < 4; i++) chk("bp hold", s[d][i], exp_ct[i]);
    end
    out_ready[d] = 1'b1; start[d] = start_in_done;
    step();
    out_ready[d] = 1'b0; start[d] = 1'b0; key_valid[d] = 1'b0;
    chk("accept out_valid", 32'(out_valid[d]), 32'd0);
    chk("accept busy", 32'(busy[d]), 32'd0);
    chk("accept count", 32'(count[d]), 32'd0);
  endtask

  task automatic reset_mid(input int d, input int at);
    set_init(d, 1'b0);
    start[d] = 1'b1; key_valid[d] = 1'b1;
    step();
    start[d] = 1'b0;
    for (int k = 1; k < at; k++) step();
    chk("pre-reset count", 32'(count[d]), 32'(at));
    rst_n = 1'b0;
    #1;
    chk_zero(d, "async reset");
    for (int c = 0; c < 3; c++) begin
      start[d] = $urandom_range(0, 1) == 1;
      key_valid[d] = $urandom_range(0, 1) == 1;
      out_ready[d] = $urandom_range(0, 1) == 1;
      step();
      chk_zero(d, "held reset");
    end
    start[d] = 1'b0; key_valid[d] = 1'b0; out_ready[d] = 1'b0;
    rst_n = 1'b1;
    step();
    chk_zero(d, "after release");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; key_valid[d] = 1'b0; out_ready[d] = 1'b0;
      set_init(d, 1'b0);
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++) begin
        start[d] = $urandom_range(0, 1) == 1;
        key_valid[d] = $urandom_range(0, 1) == 1;
      end
      step();
      chk_zero(0, "reset d0");
      chk_zero(1, "reset d1");
    end
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; key_valid[d] = 1'b0; end
    rst_n = 1'b1;
    step();
    chk_zero(0, "idle d0");
    key_valid[0] = 1'b1; out_ready[0] = 1'b1;
    step();
    chk_zero(0, "idle ignores inputs");
    key_valid[0] = 1'b0; out_ready[0] = 1'b0;

    run_block(0, 10, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    run_block(0, 10, 1'b0, 5, 3, 1'b0, 0, 1'b0);
    run_block(0, 10, 1'b0, 0, 0, 1'b0, 5, 1'b1);
    run_block(0, 10, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    reset_mid(0, 6);
    run_block(0, 10, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 4; r++)
      run_block(0, 10, 1'b1, 0, 0, 1'b1, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    run_block(1, 14, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    run_block(1, 14, 1'b1, 0, 0, 1'b1, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
